servo_sequencer: RTL
====================

Name: servo_sequencer

Overview:
Memory-mapped multi-channel servo controller. One shared tick prescaler and one frame scheduler drive NUM_CH servo pins, with one fixed time slot per channel inside each 20 ms frame. Each channel's commanded position is slew-limited toward a CPU-written target once per frame. The block sits on the same 8-bit I/O bus as the other peripherals.

Parameters:
BASE_ADDRESS, 8'h00, first register address of the block
NUM_CH, 4, number of servo channels (1..7; NUM_CH*SLOT_TICKS <= FRAME_TICKS)
CLK_FREQ, 16000000, clk frequency in Hz; SCALE = ceil(6.35e-6*CLK_FREQ) clocks per tick (102 at 16 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
din  in  8  write data
address  in  8  register address
w_en  in  1  write strobe
r_en  in  1  read strobe
dout  out  8  read data, registered
servo_pins  out  NUM_CH  servo PWM outputs, registered, bit i = channel i

Behaviour:
- Reset (async, active-high): TARGET[i]=128, CUR[i]=128, CTRL=0, STEP=0, FRAME flag=0, dout=0, servo_pins=0, FSM=IDLE, all counters=0.
- Register map, offsets from BASE_ADDRESS:
  - 0..NUM_CH-1: TARGET[i], RW.
  - NUM_CH: CTRL, RW. Bit0=EN; bits7:1 read 0.
  - NUM_CH+1: STEP, RW. 0 means jump to target.
  - NUM_CH+2: STATUS, RO. Bit0=FRAME (sticky); bit1=SETTLED (all CUR==TARGET); bits4:2=active channel; others 0.
  - NUM_CH+3+i: CUR[i], RO.
- Writes take effect on the clk edge where w_en=1. Writes to RO or unmapped addresses are ignored.
- Reads have 1-cycle latency.
  - dout <= register value if r_en and the address is mapped, else dout <= 0.
  - A STATUS read clears FRAME. If a frame-end set occurs in the same cycle, the set wins; the read returns the pre-set value.
- Tick: prescaler counts 0..SCALE-1 while EN=1 and issues a 1-clk tick at SCALE-1. It is held at 0 while EN=0.
- Time constants in ticks: MIN_TICKS=91, SLOT_TICKS=400, FRAME_TICKS=3150.
- Frame counter fc runs 0..3149 and advances on each tick. Channel i's slot starts at fc = i*400.
- FSM states and transitions:
  - IDLE: all pins 0. Goes to PULSE(ch0) on the clk after EN rises, with fc=0.
  - PULSE: servo_pins[ch]=1. Lasts exactly MIN_TICKS+CUR[ch] ticks, measured from the slot start, then goes to GAP.
  - GAP: pin low. When fc reaches the next slot start, goes to PULSE(ch+1). After the last channel, goes to WAIT.
  - WAIT: on the tick where fc wraps 3149 to 0, goes to UPDATE.
  - UPDATE (1 clk): set FRAME. For every i, compute d = TARGET[i]-CUR[i] as 9-bit signed, no wrap. If STEP=0 or |d|<=STEP, CUR[i]=TARGET[i]; else CUR[i] moves by STEP toward TARGET[i]. Then go to PULSE(ch0).
- Pulse width is 91..346 ticks, always shorter than a 400-tick slot, so pulses never overlap. At most one pin is high at any time.
- A TARGET write mid-frame does not affect the pulse in progress. It only changes CUR at the next UPDATE.
- EN cleared in any state:
  - Next clk: all pins 0, FSM=IDLE, prescaler=0, fc=0.
  - CUR and TARGET are retained.
  - Re-enabling starts a full new frame at ch0.

Decomposition:
- Package servo_pkg:
  - MIN_TICKS, SLOT_TICKS, FRAME_TICKS.
  - State enum {IDLE, PULSE, GAP, WAIT, UPDATE}.
  - Register offset constants.
  - SCALE computation function.
- One sub-module, servo_tick_prescaler. Inputs clk, rst, en; output tick. Parameter CLK_FREQ.

Test Plan:
(Bench uses CLK_FREQ=1000000, so SCALE=7, tick=7 clks, frame=22050 clks.)
1. Reset, then write CTRL=1 with all TARGET at reset 128 -> pins rise in order. Each pin is high for (91+128)*7=1533 clks. Rising edges are 2800 clks apart. Rising edges of pin0 are 22050 clks apart. Never two pins high at once.
2. Write TARGET0=0 and TARGET1=255 with STEP=0 -> after the next UPDATE, pin0 is high for 637 clks and pin1 for 2422 clks. CUR0 reads 0. STATUS.SETTLED=1.
3. CUR2=128, STEP=10, write TARGET2=150 -> CUR2 reads 138, 148, 150 after successive frames. SETTLED=0 until CUR2=150, then 1.
4. Write CTRL=0 in the middle of a pin1 pulse -> pin1 low on the next clk and stays low. Write CTRL=1 -> pin0 rises 1 clk later with a full-frame schedule.
5. Read STATUS after a frame -> bit0=1, and dout is valid 1 clk after r_en. An immediate second read returns bit0=0. A read at an unmapped address (BASE+15) -> dout=0.
6. Assert rst asynchronously mid-pulse -> pins, dout and CTRL go to 0 without a clk edge. TARGET and CUR read 128 after release.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and tick-scale helper for the servo sequencer.
package servo_pkg;

  localparam int unsigned MIN_TICKS   = 91;
  localparam int unsigned SLOT_TICKS  = 400;
  localparam int unsigned FRAME_TICKS = 3150;

  localparam int unsigned FC_W = 12;
  localparam int unsigned CH_W = 3;

  // Register offsets past the TARGET bank; add NUM_CH to get the real offset
  localparam int unsigned OFS_CTRL   = 0;
  localparam int unsigned OFS_STEP   = 1;
  localparam int unsigned OFS_STATUS = 2;
  localparam int unsigned OFS_CUR    = 3;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    GAP,
    WAIT,
    UPDATE
  } state_t;

  // Clocks per 6.35 us tick, rounded up
  function automatic int unsigned calc_scale(input longint unsigned clk_freq);
    longint unsigned num;
    num = clk_freq * 64'd635 + 64'd99_999_999;
    return 32'(num / 64'd100_000_000);
  endfunction

endpackage

// File: rtl/servo_tick_prescaler.sv
// Shared tick prescaler: one-clock tick every SCALE clocks while enabled.
module servo_tick_prescaler
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 16000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned SCALE = calc_scale(64'(CLK_FREQ));
  localparam int unsigned CNT_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(SCALE - 1));
  assign tick = en & wrap;

  // Count 0..SCALE-1, held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/servo_sequencer.sv
// Memory-mapped multi-channel servo controller with per-frame slew limiting.
module servo_sequencer
  import servo_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CLK_FREQ     = 16000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic [7:0]        address,
  input  logic              w_en,
  input  logic              r_en,
  output logic [7:0]        dout,
  output logic [NUM_CH-1:0] servo_pins
);

  localparam int unsigned A_CTRL   = NUM_CH + OFS_CTRL;
  localparam int unsigned A_STEP   = NUM_CH + OFS_STEP;
  localparam int unsigned A_STATUS = NUM_CH + OFS_STATUS;
  localparam int unsigned A_CUR    = NUM_CH + OFS_CUR;

  logic [7:0]      target  [NUM_CH];
  logic [7:0]      cur     [NUM_CH];
  logic [7:0]      cur_upd [NUM_CH];
  logic            en;
  logic [7:0]      step;
  logic            frame;
  state_t          state;
  logic [CH_W-1:0] ch;
  logic [FC_W-1:0] fc;
  logic [FC_W-1:0] slot_start;
  logic [FC_W-1:0] pulse_end;
  logic [7:0]      cur_sel;
  logic [7:0]      ofs;
  logic [7:0]      rdata;
  logic            settled;
  logic            tick;

  assign ofs = address - BASE_ADDRESS;

  servo_tick_prescaler #(
    .CLK_FREQ(CLK_FREQ)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  // Frame position in ticks, 0..FRAME_TICKS-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc <= '0;
    end else if (!en) begin
      fc <= '0;
    end else if (tick) begin
      fc <= (fc == FC_W'(FRAME_TICKS - 1)) ? '0 : fc + FC_W'(1);
    end
  end

  // Active channel position mux and all-settled detect
  always_comb begin
    cur_sel = '0;
    settled = 1'b1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch == CH_W'(i)) cur_sel = cur[i];
      if (cur[i] != target[i]) settled = 1'b0;
    end
  end

  assign pulse_end = slot_start + FC_W'(MIN_TICKS) + FC_W'(cur_sel);

  // Next positions: jump when close enough or STEP=0, else move STEP toward target
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (step == 8'd0 ||
          ((target[i] >= cur[i]) ? (target[i] - cur[i]) : (cur[i] - target[i])) <= step) begin
        cur_upd[i] = target[i];
      end else if (target[i] > cur[i]) begin
        cur_upd[i] = cur[i] + step;
      end else begin
        cur_upd[i] = cur[i] - step;
      end
    end
  end

  // CPU-writable registers and sticky FRAME flag (frame-end set beats read clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) target[i] <= 8'd128;
      en    <= 1'b0;
      step  <= '0;
      frame <= 1'b0;
    end else begin
      if (w_en) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (ofs == 8'(i)) target[i] <= din;
        end
        if (ofs == 8'(A_CTRL)) en   <= din[0];
        if (ofs == 8'(A_STEP)) step <= din;
      end
      if (state == UPDATE) begin
        frame <= 1'b1;
      end else if (r_en && ofs == 8'(A_STATUS)) begin
        frame <= 1'b0;
      end
    end
  end

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ofs == 8'(i))         rdata = target[i];
      if (ofs == 8'(A_CUR + i)) rdata = cur[i];
    end
    if (ofs == 8'(A_CTRL))   rdata = {7'd0, en};
    if (ofs == 8'(A_STEP))   rdata = step;
    if (ofs == 8'(A_STATUS)) rdata = {3'd0, ch, settled, frame};
  end

  // Registered read port, one-cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= r_en ? rdata : '0;
    end
  end

  // Frame scheduler: one pulse per channel slot, then wait for wrap and update CUR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      slot_start <= '0;
      servo_pins <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cur[i] <= 8'd128;
    end else if (!en) begin
      state      <= IDLE;
      ch         <= '0;
      slot_start <= '0;
      servo_pins <= '0;
    end else begin
      case (state)
        IDLE: begin
          state      <= PULSE;
          ch         <= '0;
          slot_start <= '0;
          servo_pins <= NUM_CH'(1);
        end
        PULSE: begin
          if (fc == pulse_end) begin
            state      <= GAP;
            servo_pins <= '0;
          end
        end
        GAP: begin
          if (ch == CH_W'(NUM_CH - 1)) begin
            state <= WAIT;
          end else if (fc == slot_start + FC_W'(SLOT_TICKS)) begin
            state      <= PULSE;
            ch         <= ch + CH_W'(1);
            slot_start <= slot_start + FC_W'(SLOT_TICKS);
            servo_pins <= NUM_CH'(1) << (ch + CH_W'(1));
          end
        end
        WAIT: begin
          if (tick && fc == FC_W'(FRAME_TICKS - 1)) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < int'(NUM_CH); i++) cur[i] <= cur_upd[i];
          state      <= PULSE;
          ch         <= '0;
          slot_start <= '0;
          servo_pins <= NUM_CH'(1);
        end
        default: begin
          state      <= IDLE;
          servo_pins <= '0;
        end
      endcase
    end
  end

endmodule
